game_step_timer: RTL

- Consumer end of the game-speed clock: takes the slow game-speed square wave `clk10` (normal about 10 Hz, difficult about 20 Hz) into the system clock domain.
- Turns each rising edge into a one-cycle `step` strobe for the game logic.
- Runs the round countdown in seconds: converts steps to seconds according to `game_level`.
- Raises `timeout` when the round ends; supports start and pause.

---
 rtl/game_timing_pkg.sv | 17 +
 rtl/slow_edge_sync.sv | 28 ++
 rtl/game_step_timer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/game_timing_pkg.sv
// Shared state encoding, level constants and step-rate defaults for the game step timer.
package game_timing_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic LEVEL_NORMAL = 1'b0;
    localparam logic LEVEL_HARD   = 1'b1;

    localparam int DEFAULT_STEPS_NORMAL = 10;
    localparam int DEFAULT_STEPS_HARD   = 20;

endpackage

// File: rtl/slow_edge_sync.sv
// Brings the slow game-speed square wave into the clk domain and emits a
// registered one-cycle pulse per rising edge.
module slow_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            prev  <= sync2;
            rise  <= sync2 & ~prev;
        end
    end

endmodule

// File: rtl/game_step_timer.sv
// Game step strobe and round countdown driven by the slow clk10 wave.
// Optional bonus-seconds input is enabled by defining GAME_STEP_BONUS_EN.
module game_step_timer
    import game_timing_pkg::*;
#(
    parameter int GAME_SECONDS = 60,
    parameter int STEPS_NORMAL = DEFAULT_STEPS_NORMAL,
    parameter int STEPS_HARD   = DEFAULT_STEPS_HARD,
    parameter int TIME_W       = 8
`ifdef GAME_STEP_BONUS_EN
    ,
    parameter int BONUS_SECONDS = 5
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk10,
    input  logic              game_level,
    input  logic              start,
    input  logic              pause,
`ifdef GAME_STEP_BONUS_EN
    input  logic              bonus,
`endif
    output logic              step,
    output logic [TIME_W-1:0] time_left,
    output logic              running,
    output logic              timeout,
    output logic [1:0]        state
);

    localparam int unsigned TIME_MAX = (32'd1 << TIME_W) - 32'd1;

    state_t      cur_state;
    logic [4:0]  step_count;
    logic        edge_rise;
    logic        emit;
    logic [5:0]  threshold;
    logic [5:0]  count_next;
    logic        second_done;
    logic        timeout_hit;
    logic [TIME_W-1:0] time_next;
    int unsigned time_calc;

    slow_edge_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (clk10),
        .rise     (edge_rise)
    );

    assign state = cur_state;

    // Pause wins over a coincident edge; edges outside RUN are simply dropped.
    always_comb begin
        emit        = (cur_state == RUN) && edge_rise && !pause;
        threshold   = (game_level == LEVEL_HARD) ? 6'(STEPS_HARD) : 6'(STEPS_NORMAL);
        count_next  = {1'b0, step_count} + 6'd1;
        second_done = emit && (count_next >= threshold);
        time_calc   = {{(32-TIME_W){1'b0}}, time_left};
        if (second_done && time_calc != 0) begin
            time_calc = time_calc - 32'd1;
        end
`ifdef GAME_STEP_BONUS_EN
        if (bonus && (cur_state == RUN || cur_state == PAUSED)) begin
            time_calc = time_calc + 32'(BONUS_SECONDS);
            if (time_calc > TIME_MAX) begin
                time_calc = TIME_MAX;
            end
        end
`endif
        time_next   = time_calc[TIME_W-1:0];
        timeout_hit = second_done && (time_next == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state  <= IDLE;
            step       <= 1'b0;
            timeout    <= 1'b0;
            running    <= 1'b0;
            time_left  <= '0;
            step_count <= '0;
        end else begin
            step    <= emit;
            timeout <= 1'b0;
            case (cur_state)
                IDLE, DONE: begin
                    if (start) begin
                        cur_state  <= RUN;
                        running    <= 1'b1;
                        time_left  <= TIME_W'(GAME_SECONDS);
                        step_count <= '0;
                    end
                end
                RUN: begin
                    time_left <= time_next;
                    if (pause) begin
                        cur_state <= PAUSED;
                        running   <= 1'b0;
                    end else if (timeout_hit) begin
                        cur_state <= DONE;
                        running   <= 1'b0;
                        timeout   <= 1'b1;
                    end else if (emit) begin
                        step_count <= second_done ? 5'd0 : count_next[4:0];
                    end
                end
                PAUSED: begin
                    time_left <= time_next;
                    if (!pause) begin
                        cur_state <= RUN;
                        running   <= 1'b1;
                    end
                end
                default: begin
                    cur_state <= IDLE;
                    running   <= 1'b0;
                end
            endcase
        end
    end

endmodule
